// File: rtl/pix_byte_packer.sv
// Pixel byte packer: buffers 12-bit camera pixels in a small FIFO and emits a
// self-framing byte stream (2-bit type prefix per byte) over valid/ready.
// Optional line markers are compiled in when PIXPK_LINE_MARK_EN is defined.
module pix_byte_packer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [11:0] pix_data,
  input  logic        wr_cmplt,
  input  logic        vsync,
  input  logic        href,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [5:0]  frame_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr   = 3'd1,
    StPixHi = 3'd2,
`ifdef PIXPK_LINE_MARK_EN
    StPixLo = 3'd3,
    StLine  = 3'd4
`else
    StPixLo = 3'd3
`endif
  } state_e;

  // Synchronisers and edge detectors
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] vs_sync_q, vs_sync_d;
  logic                   wr_prev_q, vs_prev_q;
  logic                   wr_rise_q, wr_rise_d;
  logic                   vs_rise_q, vs_rise_d;
  logic [11:0]            pix_cap_q, pix_cap_d;

  // FIFO
  logic [11:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fifo_full, fifo_empty, push_ok, pop;
  logic [11:0]     rd_word;

  // Framing / output
  state_e      state_q, state_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [5:0]  hold_lo_q, hold_lo_d;
  logic        hdr_pend_q, hdr_pend_d, hdr_clr;
  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic        overflow_q, overflow_d;
  logic        handshake;

`ifdef PIXPK_LINE_MARK_EN
  logic [SYNC_STAGES-1:0] hr_sync_q, hr_sync_d;
  logic                   hr_prev_q;
  logic                   hr_fall_q, hr_fall_d;
  logic                   line_pend_q, line_pend_d, line_clr;
  logic [5:0]             line_cnt_q, line_cnt_d;
`else
  logic unused_href;
  assign unused_href = href;
`endif

  // Shift async inputs through the sync chain; edge pulses are registered,
  // and the pixel word is captured on the same clock its edge is detected.
  always_comb begin
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], wr_cmplt};
    vs_sync_d = {vs_sync_q[SYNC_STAGES-2:0], vsync};
    wr_rise_d = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
    vs_rise_d = vs_sync_q[SYNC_STAGES-1] & ~vs_prev_q;
    pix_cap_d = wr_rise_d ? pix_data : pix_cap_q;
`ifdef PIXPK_LINE_MARK_EN
    hr_sync_d = {hr_sync_q[SYNC_STAGES-2:0], href};
    hr_fall_d = ~hr_sync_q[SYNC_STAGES-1] & hr_prev_q;
`endif
  end

  assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign rd_word    = mem_q[rd_ptr_q];
  assign handshake  = out_valid_q & out_ready;

  // FIFO pointers: a frame flush is applied before the same-cycle push,
  // and a pop frees a slot for a push arriving while full.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    push_ok    = wr_rise_q & (~fifo_full | pop | vs_rise_q);
    overflow_d = overflow_q | (wr_rise_q & ~push_ok);
    if (vs_rise_q) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      cnt_d    = cnt_q - CntW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      cnt_d    = cnt_d + CntW'(1);
    end
  end

  // Pending header / frame counter (and line marker bookkeeping)
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    hdr_pend_d  = hdr_pend_q;
    if (vs_rise_q) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
      hdr_pend_d  = 1'b1;
    end else if (hdr_clr) begin
      hdr_pend_d = 1'b0;
    end
`ifdef PIXPK_LINE_MARK_EN
    line_cnt_d  = line_cnt_q;
    line_pend_d = line_pend_q;
    if (vs_rise_q) begin
      line_cnt_d = 6'd0;
    end else if (hr_fall_q) begin
      line_cnt_d = line_cnt_q + 6'd1;
    end
    if (hr_fall_q && !vs_rise_q) begin
      line_pend_d = 1'b1;
    end else if (line_clr) begin
      line_pend_d = 1'b0;
    end
`endif
  end

  // Byte framing FSM: every byte is loaded in one state and handed off with
  // valid dropping for one cycle between consecutive bytes.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    hold_lo_d   = hold_lo_q;
    pop         = 1'b0;
    hdr_clr     = 1'b0;
`ifdef PIXPK_LINE_MARK_EN
    line_clr    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (hdr_pend_q) begin
          out_data_d  = {2'b11, frame_cnt_q};
          out_valid_d = 1'b1;
          state_d     = StHdr;
`ifdef PIXPK_LINE_MARK_EN
        end else if (line_pend_q) begin
          out_data_d  = {2'b00, line_cnt_q};
          out_valid_d = 1'b1;
          state_d     = StLine;
`endif
        end else if (!fifo_empty) begin
          pop         = 1'b1;
          hold_lo_d   = rd_word[5:0];
          out_data_d  = {2'b10, rd_word[11:6]};
          out_valid_d = 1'b1;
          state_d     = StPixHi;
        end
      end
      StHdr: begin
        if (handshake) begin
          hdr_clr     = 1'b1;
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
`ifdef PIXPK_LINE_MARK_EN
      StLine: begin
        if (handshake) begin
          line_clr    = 1'b1;
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
`endif
      StPixHi: begin
        if (handshake) begin
          out_data_d  = {2'b01, hold_lo_q};
          out_valid_d = 1'b0;
          state_d     = StPixLo;
        end
      end
      StPixLo: begin
        // Low byte was loaded on the high-byte handshake; raise valid now.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_sync_q   <= '0;
      vs_sync_q   <= '0;
      wr_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      wr_rise_q   <= 1'b0;
      vs_rise_q   <= 1'b0;
      pix_cap_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= StIdle;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      hold_lo_q   <= '0;
      hdr_pend_q  <= 1'b0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_sync_q   <= wr_sync_d;
      vs_sync_q   <= vs_sync_d;
      wr_prev_q   <= wr_sync_q[SYNC_STAGES-1];
      vs_prev_q   <= vs_sync_q[SYNC_STAGES-1];
      wr_rise_q   <= wr_rise_d;
      vs_rise_q   <= vs_rise_d;
      pix_cap_q   <= pix_cap_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      hold_lo_q   <= hold_lo_d;
      hdr_pend_q  <= hdr_pend_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef PIXPK_LINE_MARK_EN
  // Line marker registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hr_sync_q   <= '0;
      hr_prev_q   <= 1'b0;
      hr_fall_q   <= 1'b0;
      line_pend_q <= 1'b0;
      line_cnt_q  <= '0;
    end else begin
      hr_sync_q   <= hr_sync_d;
      hr_prev_q   <= hr_sync_q[SYNC_STAGES-1];
      hr_fall_q   <= hr_fall_d;
      line_pend_q <= line_pend_d;
      line_cnt_q  <= line_cnt_d;
    end
  end
`endif

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= pix_cap_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pix_byte_packer.sv
// Self-checking bench for pix_byte_packer: random pixels and handshake stalls
// compared against a byte-stream model built from the framing rules.
module tb_pix_byte_packer;

  localparam int unsigned FifoDepth  = 16;
  localparam int unsigned SyncStages = 2;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [11:0] pix_data = '0;
  logic        wr_cmplt = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        overflow;
  logic [5:0]  frame_cnt;

  pix_byte_packer #(
    .FIFO_DEPTH (FifoDepth),
    .SYNC_STAGES(SyncStages)
  ) u_dut (
    .clk      (clk),
    .nReset   (nReset),
    .pix_data (pix_data),
    .wr_cmplt (wr_cmplt),
    .vsync    (vsync),
    .href     (href),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         stab_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         m_frame = 0;
  int         m_line = 0;
  int         m_ovf = 0;
  bit         done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Record accepted bytes; flag any change of a stalled byte.
  logic       mon_v = 1'b0;
  logic       mon_r = 1'b0;
  logic [7:0] mon_d = '0;
  always @(negedge clk) begin
    if (!nReset) begin
      mon_v <= 1'b0;
    end else begin
      if (mon_v && !mon_r && (!out_valid || out_data != mon_d)) stab_err <= stab_err + 1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      mon_v <= out_valid;
      mon_r <= out_ready;
      mon_d <= out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [11:0] p);
    tick();
    pix_data = p;
    wr_cmplt = 1'b1;
    repeat (3) tick();
    wr_cmplt = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_vsync();
    tick();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_href();
    tick();
    href = 1'b1;
    repeat (3) tick();
    href = 1'b0;
    repeat (3) tick();
  endtask

  // Reference model: each event appends the bytes the host should receive.
  task automatic m_pix(input logic [11:0] p);
    exp_q.push_back({2'b10, p[11:6]});
    exp_q.push_back({2'b01, p[5:0]});
  endtask

  task automatic m_hdr();
    m_frame = (m_frame + 1) % 64;
    m_line  = 0;
    exp_q.push_back({2'b11, 6'(m_frame)});
  endtask

  task automatic m_reset();
    m_frame = 0;
    m_line  = 0;
    m_ovf   = 0;
  endtask

  task automatic drain_cmp(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      tick();
      n++;
    end
    repeat (20) tick();
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] p, a, b, c;
    int lat, cnt, nb;

    // Reset state
    nReset = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h00);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_frame", 32'(frame_cnt), 32'd0);
    nReset = 1'b1;
    m_reset();
    tick();

    // First pixel and pin-to-valid latency
    lat = 0;
    tick();
    pix_data = 12'hABC;
    wr_cmplt = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) wr_cmplt = 1'b0;
      if (out_valid && lat == 0) lat = k;
    end
    m_pix(12'hABC);
    check_eq("latency", 32'(lat), 32'(SyncStages + 3));
    drain_cmp("pix_abc");
    check_eq("ovf_clean", 32'(overflow), 32'(m_ovf));

    // New frame header then a pixel
    pulse_vsync();
    m_hdr();
    send_pix(12'h001);
    m_pix(12'h001);
    drain_cmp("frame1");
    check_eq("frame_cnt1", 32'(frame_cnt), 32'(m_frame));

    // Header stalled, 17 pixels into a 16-deep FIFO
    tick();
    out_ready = 1'b0;
    pulse_vsync();
    m_hdr();
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      p = 12'($urandom);
      send_pix(p);
      if (cnt < int'(FifoDepth)) begin
        m_pix(p);
        cnt++;
      end else begin
        m_ovf = 1;
      end
    end
    check_eq("ovf_set", 32'(overflow), 32'(m_ovf));
    check_eq("ovf_stalled", 32'(got_q.size()), 32'd0);
    tick();
    out_ready = 1'b1;
    drain_cmp("ovf");
    check_eq("ovf_sticky", 32'(overflow), 32'(m_ovf));
    check_eq("frame_cnt2", 32'(frame_cnt), 32'(m_frame));

    // Reset clears sticky overflow and frame counter
    tick();
    nReset = 1'b0;
    repeat (2) tick();
    check_eq("rst2_ovf", 32'(overflow), 32'd0);
    check_eq("rst2_frame", 32'(frame_cnt), 32'd0);
    nReset = 1'b1;
    m_reset();
    tick();

    // 64 frames wrap the counter back to zero
    for (int i = 0; i < 64; i++) begin
      pulse_vsync();
      m_hdr();
    end
    check_eq("wrap_frame", 32'(frame_cnt), 32'(m_frame));
    drain_cmp("wrap");

    // Random pixel bursts under random backpressure
    for (int burst = 0; burst < 6; burst++) begin
      done = 1'b0;
      fork
        begin
          nb = $urandom_range(3, 6);
          for (int i = 0; i < nb; i++) begin
            p = 12'($urandom);
            send_pix(p);
            m_pix(p);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      out_ready = 1'b1;
      drain_cmp($sformatf("rand%0d", burst));
    end
    check_eq("stable_rand", 32'(stab_err), 32'd0);

    // Frame start flushes queued pixels; the held pixel still completes
    tick();
    out_ready = 1'b0;
    a = 12'($urandom);
    b = 12'($urandom);
    c = 12'($urandom);
    send_pix(a);
    m_pix(a);
    send_pix(b);
    send_pix(c);
    pulse_vsync();
    m_hdr();
    tick();
    out_ready = 1'b1;
    drain_cmp("flush");

    // Reset while the low byte is stalled
    tick();
    out_ready = 1'b0;
    p = 12'($urandom);
    send_pix(p);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_q.push_back({2'b10, p[11:6]});
    repeat (3) tick();
    check_eq("lo_held_valid", 32'(out_valid), 32'd1);
    check_eq("lo_held_data", 32'(out_data), 32'({2'b01, p[5:0]}));
    nReset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(out_data), 32'h00);
    repeat (2) tick();
    nReset = 1'b1;
    m_reset();
    tick();
    out_ready = 1'b1;
    p = 12'($urandom);
    send_pix(p);
    m_pix(p);
    drain_cmp("rst_mid");
    check_eq("rst_mid_frame", 32'(frame_cnt), 32'(m_frame));

    // HREF falling edges: markers only when the feature is built in
    for (int i = 0; i < 2; i++) begin
      pulse_href();
`ifdef PIXPK_LINE_MARK_EN
      m_line = (m_line + 1) % 64;
      exp_q.push_back({2'b00, 6'(m_line)});
`endif
      repeat (4) tick();
    end
    drain_cmp("line");

    check_eq("stable_all", 32'(stab_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
